spi_txn_arbiter: RTL and testbench
==================================

Name: spi_txn_arbiter

Overview:
- Shares one spi_master byte interface among NUM_REQ client requesters.
- Each request is a multi-byte transaction to one slave (0-7).
- Round-robin arbitration picks a requester. The block then sequences its bytes into the master one at a time, routes MISO bytes back, and signals completion or timeout.
- Sits between client engines (flash reader, ADC poller, etc.) and spi_master.

Parameters:
- NUM_REQ, 4, number of requesters (2-8)
- LEN_W, 8, width of per-request byte count (max 2^LEN_W-1 bytes)
- TIMEOUT_CYCLES, 1024, i_clk cycles allowed in WAIT_RX before abort

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_req  in  NUM_REQ  level request per client; held until o_done/o_err
- i_req_slave  in  3*NUM_REQ  slave index per client, slice k = [3k+2:3k]
- i_req_len  in  LEN_W*NUM_REQ  byte count per client
- i_tx_byte  in  8*NUM_REQ  next MOSI byte per client
- o_grant  out  NUM_REQ  one-hot, high for the whole active transaction
- o_tx_take  out  NUM_REQ  1-cycle pulse: client's i_tx_byte consumed, present next byte by the following cycle
- o_rx_valid  out  NUM_REQ  1-cycle pulse: o_rx_byte valid for that client
- o_rx_byte  out  8  MISO byte, shared bus
- o_done  out  NUM_REQ  1-cycle pulse at normal completion
- o_err  out  NUM_REQ  1-cycle pulse at timeout abort
- o_m_tx_data_valid  out  1  to spi_master i_tx_data_valid
- o_m_tx_data_byte  out  8  to spi_master i_tx_data_byte
- o_m_slave_select  out  3  to spi_master i_slave_select
- i_m_tx_ready  in  1  from spi_master o_tx_ready
- i_m_rx_data_valid  in  1  from spi_master o_rx_data_valid
- i_m_rx_data_byte  in  8  from spi_master o_rx_data_byte

Behaviour:
- Reset (sync, i_rst=1 at posedge):
  - state=IDLE, rr pointer=0, counters=0.
  - All outputs 0, including o_rx_byte, o_m_tx_data_byte and o_m_slave_select.
  - Reset mid-transaction aborts silently: no o_done/o_err pulse.
- States: IDLE, SEND, WAIT_RX, DONE, ERR.
- IDLE:
  - If any i_req, pick the first set bit at or after rr pointer (wrapping).
  - Latch slave index into o_m_slave_select and len into rem counter; set o_grant one-hot.
  - Next state is SEND, or DONE if len==0 (zero-length request: o_done only, no bytes).
  - Grant asserts 1 cycle after i_req is seen.
- SEND:
  - When i_m_tx_ready=1: for one cycle, o_m_tx_data_valid=1, o_m_tx_data_byte=granted i_tx_byte, o_tx_take[g]=1.
  - Decrement rem, clear timeout counter, go to WAIT_RX.
  - Never asserts valid while i_m_tx_ready=0.
- WAIT_RX:
  - On i_m_rx_data_valid: o_rx_byte=i_m_rx_data_byte and o_rx_valid[g]=1 next cycle. Go to DONE if rem==0, else SEND.
  - Timeout counter increments each cycle. On reaching TIMEOUT_CYCLES-1 without rx, go to ERR.
- DONE/ERR:
  - o_done[g] or o_err[g] pulses 1 cycle; o_grant drops the same cycle.
  - rr pointer = (g+1) mod NUM_REQ; return to IDLE. A new grant is possible on the next cycle.
- Exactly one byte outstanding at the master at any time; CS framing is left to spi_master (it sees back-to-back valid within a transaction).
- i_req deasserted mid-transaction is ignored; the transaction runs to completion.
- i_m_rx_data_valid outside WAIT_RX is ignored (no o_rx_valid).
- Requester still asserting i_req on its o_done cycle is re-arbitrated behind the others (fairness).
- i_req_slave/i_req_len are sampled only at grant; later changes have no effect.
- Transaction bytes = len exactly; rem underflow is impossible because of the rem==0 check.

Decomposition:
- Package spi_ctrl_pkg:
  - state encodings (localparam)
  - SLAVE_W=3, BYTE_W=8
  - helper function for one-hot-to-index
- Sub-module rr_arbiter (param NUM_REQ):
  - combinational pick from req and pointer
  - outputs one-hot grant + index
  - pointer register lives in spi_txn_arbiter.

Test Plan:
- Single client 0, slave=5, len=3, tx bytes A1,B2,C3; stub master loops back ~byte after 6 cycles:
  - o_m_slave_select=5
  - three o_tx_take[0] pulses
  - o_rx_valid[0] bytes 5E,4D,3C
  - o_done[0] once, grant 0 throughout.
- i_req=4'b1111 held continuously, len=1 each:
  - grant order 0,1,2,3,0.
  - o_grant never multi-hot; one cycle of no grant between transactions.
- len=0 on client 2:
  - o_done[2] two cycles after i_req.
  - o_m_tx_data_valid never asserted.
- Master stub never returns rx, TIMEOUT_CYCLES=16:
  - o_err[g] pulse 16 cycles after the send.
  - grant released; next requester served.
- i_m_tx_ready held low 10 cycles in SEND:
  - o_m_tx_data_valid stays 0.
  - asserts the cycle ready rises; spurious rx_valid in SEND produces no o_rx_valid.
- i_rst pulsed during WAIT_RX of a len=4 transfer:
  - all outputs 0 next cycle, no o_done/o_err.
  - fresh request then granted to client 0.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI transaction arbiter.
// Holds the controller state encoding, bus widths and a one-hot decoder.
package spi_ctrl_pkg;

    localparam int SLAVE_W = 3;
    localparam int BYTE_W  = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_RX = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERR     = 3'd4
    } state_t;

    // Index of the set bit in a one-hot vector of up to eight requesters.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/spi_txn_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
// The pointer register is owned by the caller.
module rr_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx
);

    logic [IDX_W-1:0] k;

    always_comb begin
        grant = '0;
        k     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (grant == '0 && req[k]) begin
                grant[k] = 1'b1;
            end
        end
        idx = IDX_W'(onehot_to_idx(8'(grant)));
    end

endmodule

// File: rtl/spi_txn_arbiter.sv
// Shares one spi_master byte interface among NUM_REQ clients, running one
// multi-byte transaction at a time with a single byte outstanding at the master.
module spi_txn_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [SLAVE_W*NUM_REQ-1:0] i_req_slave,
    input  logic [LEN_W*NUM_REQ-1:0]   i_req_len,
    input  logic [BYTE_W*NUM_REQ-1:0]  i_tx_byte,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [NUM_REQ-1:0]         o_tx_take,
    output logic [NUM_REQ-1:0]         o_rx_valid,
    output logic [BYTE_W-1:0]          o_rx_byte,
    output logic [NUM_REQ-1:0]         o_done,
    output logic [NUM_REQ-1:0]         o_err,
    output logic                       o_m_tx_data_valid,
    output logic [BYTE_W-1:0]          o_m_tx_data_byte,
    output logic [SLAVE_W-1:0]         o_m_slave_select,
    input  logic                       i_m_tx_ready,
    input  logic                       i_m_rx_data_valid,
    input  logic [BYTE_W-1:0]          i_m_rx_data_byte
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [BYTE_W-1:0]  tx_bytes  [NUM_REQ];
    logic [SLAVE_W-1:0] req_slave [NUM_REQ];
    logic [LEN_W-1:0]   req_len   [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign tx_bytes[gi]  = i_tx_byte[BYTE_W*gi +: BYTE_W];
            assign req_slave[gi] = i_req_slave[SLAVE_W*gi +: SLAVE_W];
            assign req_len[gi]   = i_req_len[LEN_W*gi +: LEN_W];
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   rr_ptr_reg;
    logic [NUM_REQ-1:0] grant_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [SLAVE_W-1:0] slave_reg;
    logic [LEN_W-1:0]   rem_reg;
    logic [TMO_W-1:0]   tmo_reg;
    logic [BYTE_W-1:0]  rx_byte_reg;
    logic [NUM_REQ-1:0] rx_valid_reg;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req   (i_req),
        .ptr   (rr_ptr_reg),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            grant_reg    <= '0;
            idx_reg      <= '0;
            slave_reg    <= '0;
            rem_reg      <= '0;
            tmo_reg      <= '0;
            rx_byte_reg  <= '0;
            rx_valid_reg <= '0;
        end else begin
            state_reg    <= state_next;
            rx_valid_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    // Slave and length are captured here only; later changes are ignored.
                    if (|i_req) begin
                        grant_reg <= arb_grant;
                        idx_reg   <= arb_idx;
                        slave_reg <= req_slave[arb_idx];
                        rem_reg   <= req_len[arb_idx];
                    end
                end
                ST_SEND: begin
                    if (i_m_tx_ready) begin
                        rem_reg <= rem_reg - 1'b1;
                        tmo_reg <= '0;
                    end
                end
                ST_WAIT_RX: begin
                    if (i_m_rx_data_valid) begin
                        rx_byte_reg  <= i_m_rx_data_byte;
                        rx_valid_reg <= grant_reg;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    grant_reg  <= '0;
                    rr_ptr_reg <= (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next        = state_reg;
        o_grant           = '0;
        o_tx_take         = '0;
        o_done            = '0;
        o_err             = '0;
        o_m_tx_data_valid = 1'b0;
        o_m_tx_data_byte  = '0;
        case (state_reg)
            ST_IDLE: begin
                if (|i_req) begin
                    state_next = (req_len[arb_idx] == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                o_grant = grant_reg;
                if (i_m_tx_ready) begin
                    o_m_tx_data_valid = 1'b1;
                    o_m_tx_data_byte  = tx_bytes[idx_reg];
                    o_tx_take         = grant_reg;
                    state_next        = ST_WAIT_RX;
                end
            end
            ST_WAIT_RX: begin
                o_grant = grant_reg;
                if (i_m_rx_data_valid) begin
                    state_next = (rem_reg == '0) ? ST_DONE : ST_SEND;
                end else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next = ST_ERR;
                end
            end
            ST_DONE: begin
                o_done     = grant_reg;
                state_next = ST_IDLE;
            end
            ST_ERR: begin
                o_err      = grant_reg;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign o_rx_valid       = rx_valid_reg;
    assign o_rx_byte        = rx_byte_reg;
    assign o_m_slave_select = slave_reg;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter: stimulus queues expected events,
// a negedge monitor pops and compares them as the DUT emits pulses.
module tb_spi_txn_arbiter;

    localparam int N   = 4;
    localparam int LW  = 8;
    localparam int TMO = 16;
    localparam int RXD = 6;

    localparam int EV_GRANT = 0;
    localparam int EV_RX    = 1;
    localparam int EV_TAKE  = 2;
    localparam int EV_DONE  = 3;
    localparam int EV_ERR   = 4;

    logic            clk = 1'b0;
    logic            i_rst;
    logic [N-1:0]    i_req;
    logic [3*N-1:0]  i_req_slave;
    logic [LW*N-1:0] i_req_len;
    logic [8*N-1:0]  i_tx_byte;
    logic [N-1:0]    o_grant, o_tx_take, o_rx_valid, o_done, o_err;
    logic [7:0]      o_rx_byte;
    logic            o_m_tx_data_valid;
    logic [7:0]      o_m_tx_data_byte;
    logic [2:0]      o_m_slave_select;
    logic            i_m_tx_ready;
    logic            i_m_rx_data_valid;
    logic [7:0]      i_m_rx_data_byte;

    always #5 clk = ~clk;

    spi_txn_arbiter #(
        .NUM_REQ        (N),
        .LEN_W          (LW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .i_clk             (clk),
        .i_rst             (i_rst),
        .i_req             (i_req),
        .i_req_slave       (i_req_slave),
        .i_req_len         (i_req_len),
        .i_tx_byte         (i_tx_byte),
        .o_grant           (o_grant),
        .o_tx_take         (o_tx_take),
        .o_rx_valid        (o_rx_valid),
        .o_rx_byte         (o_rx_byte),
        .o_done            (o_done),
        .o_err             (o_err),
        .o_m_tx_data_valid (o_m_tx_data_valid),
        .o_m_tx_data_byte  (o_m_tx_data_byte),
        .o_m_slave_select  (o_m_slave_select),
        .i_m_tx_ready      (i_m_tx_ready),
        .i_m_rx_data_valid (i_m_rx_data_valid),
        .i_m_rx_data_byte  (i_m_rx_data_byte)
    );

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int         kind;
        int         client;
        logic [7:0] data;
        logic [2:0] slave;
    } ev_t;

    ev_t exp_q[$];
    logic [7:0] tx_q[N][$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_GRANT: return "GRANT";
            EV_RX:    return "RX";
            EV_TAKE:  return "TAKE";
            EV_DONE:  return "DONE";
            default:  return "ERR";
        endcase
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        compared++;
        if (act < lo || act > hi) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic push_ev(input int kind, input int c, input logic [7:0] d, input logic [2:0] s);
        ev_t e;
        e.kind = kind; e.client = c; e.data = d; e.slave = s;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int c, input logic [7:0] d, input logic [2:0] s);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: got %s client %0d data %02h, expected nothing", kname(kind), c, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.client != c ||
                ((kind == EV_RX || kind == EV_TAKE) && e.data !== d) ||
                (kind == EV_TAKE && e.slave !== s)) begin
                mismatched++;
                $display("FAIL event: got %s c%0d d%02h s%0d, expected %s c%0d d%02h s%0d",
                         kname(kind), c, d, s, kname(e.kind), e.client, e.data, e.slave);
            end else begin
                $display("cycle %0d: %s client %0d data %02h slave %0d", cyc, kname(kind), c, d, s);
            end
        end
    endtask

    // mode 0: normal, 1: times out after first byte, 2: aborted by reset after first byte
    task automatic add_txn(input int c, input int sl, input int len,
                           input logic [31:0] txb, input logic [31:0] rxb, input int mode);
        i_req_slave[3*c +: 3] = 3'(sl);
        i_req_len[LW*c +: LW] = LW'(len);
        for (int i = 0; i < len; i++) tx_q[c].push_back(txb[8*i +: 8]);
        if (len > 0) push_ev(EV_GRANT, c, 8'h00, 3'd0);
        for (int i = 0; i < len; i++) begin
            push_ev(EV_TAKE, c, txb[8*i +: 8], 3'(sl));
            if (mode != 0) break;
            push_ev(EV_RX, c, rxb[8*i +: 8], 3'd0);
        end
        if (mode == 0) push_ev(EV_DONE, c, 8'h00, 3'd0);
        if (mode == 1) push_ev(EV_ERR, c, 8'h00, 3'd0);
    endtask

    // Monitor
    int grant_seen = 0, done_seen = 0, err_seen = 0;
    int last_done_cyc = 0, last_err_cyc = 0;
    int take_cyc[N];
    logic [N-1:0] prev_grant = '0;

    initial begin
        for (int k = 0; k < N; k++) take_cyc[k] = 0;
        forever begin
            @(negedge clk);
            if (!i_rst) begin
                chk("grant_onehot", 32'($countones(o_grant) <= 1), 32'd1);
                chk("valid_needs_ready", 32'(o_m_tx_data_valid & ~i_m_tx_ready), 32'd0);
                chk("take_matches_valid", 32'(o_tx_take != '0), 32'(o_m_tx_data_valid));
                if (prev_grant != '0 && o_grant != '0) chk("grant_stable", 32'(o_grant), 32'(prev_grant));
                if (prev_grant == '0 && o_grant != '0) begin
                    observe(EV_GRANT, oh_idx(o_grant), 8'h00, 3'd0);
                    grant_seen++;
                end
                for (int k = 0; k < N; k++) if (o_rx_valid[k]) observe(EV_RX, k, o_rx_byte, 3'd0);
                for (int k = 0; k < N; k++) if (o_tx_take[k]) begin
                    observe(EV_TAKE, k, o_m_tx_data_byte, o_m_slave_select);
                    take_cyc[k] = cyc;
                end
                for (int k = 0; k < N; k++) if (o_done[k]) begin
                    observe(EV_DONE, k, 8'h00, 3'd0);
                    chk("grant_drop_on_done", 32'(o_grant), 32'd0);
                    done_seen++;
                    last_done_cyc = cyc;
                end
                for (int k = 0; k < N; k++) if (o_err[k]) begin
                    observe(EV_ERR, k, 8'h00, 3'd0);
                    chk("grant_drop_on_err", 32'(o_grant), 32'd0);
                    err_seen++;
                    last_err_cyc = cyc;
                end
            end
            prev_grant = o_grant;
        end
    end

    // Master stub: loops back the inverted byte RXD cycles after each send.
    int         cd = -1;
    logic [7:0] pend = 8'h00;
    logic [N-1:0] no_resp_mask = '0;
    logic       spurious = 1'b0;

    initial begin
        i_m_rx_data_valid = 1'b0;
        i_m_rx_data_byte  = 8'h00;
        forever begin
            @(negedge clk);
            i_m_rx_data_valid = 1'b0;
            if (i_rst) begin
                cd = -1;
            end else begin
                if (spurious) begin
                    i_m_rx_data_valid = 1'b1;
                    i_m_rx_data_byte  = 8'h99;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        i_m_rx_data_valid = 1'b1;
                        i_m_rx_data_byte  = ~pend;
                        cd = -1;
                    end
                end
                if (o_m_tx_data_valid && (o_tx_take & no_resp_mask) == '0) begin
                    pend = o_m_tx_data_byte;
                    cd   = RXD;
                end
            end
        end
    end

    // Client byte sources: advance on each take.
    logic [N-1:0] take_snap = '0;
    initial begin
        i_tx_byte = '0;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < N; k++)
                if (take_snap[k] && tx_q[k].size() > 0) void'(tx_q[k].pop_front());
            for (int k = 0; k < N; k++)
                i_tx_byte[8*k +: 8] = (tx_q[k].size() > 0) ? tx_q[k][0] : 8'h00;
            @(negedge clk);
            take_snap = o_tx_take;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_fin(input string name, input int target, input int budget);
        int n = 0;
        while ((done_seen + err_seen) < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_finish_in_time"}, 32'((done_seen + err_seen) >= target), 32'd1);
    endtask

    task automatic wait_grant(input string name, input int target, input int budget);
        int n = 0;
        while (grant_seen < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_grant_in_time"}, 32'(grant_seen >= target), 32'd1);
    endtask

    task automatic wait_q_empty(input string name, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk({name, "_events_in_time"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_grant"},    32'(o_grant), 32'd0);
        chk({name, "_take"},     32'(o_tx_take), 32'd0);
        chk({name, "_rx_valid"}, 32'(o_rx_valid), 32'd0);
        chk({name, "_rx_byte"},  32'(o_rx_byte), 32'd0);
        chk({name, "_done"},     32'(o_done), 32'd0);
        chk({name, "_err"},      32'(o_err), 32'd0);
        chk({name, "_m_valid"},  32'(o_m_tx_data_valid), 32'd0);
        chk({name, "_m_byte"},   32'(o_m_tx_data_byte), 32'd0);
        chk({name, "_m_slave"},  32'(o_m_slave_select), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int base, g0, c0, d0, e0, rise_cyc;

    initial begin
        i_rst = 1'b1; i_req = '0; i_req_slave = '0; i_req_len = '0; i_m_tx_ready = 1'b1;
        tick(3);
        check_all_zero("reset");
        i_rst = 1'b0;
        tick(1);

        // Single client 0, slave 5, bytes A1 B2 C3 -> loopback 5E 4D 3C
        base = done_seen + err_seen;
        add_txn(0, 5, 3, 32'h00C3B2A1, 32'h003C4D5E, 0);
        tick(1);
        i_req = 4'b0001;
        wait_fin("t1", base + 1, 100);
        i_req = 4'b0000;
        chk("t1_slave_select", 32'(o_m_slave_select), 32'd5);
        chk("t1_events_left", 32'(exp_q.size()), 32'd0);
        tick(2);

        // Round robin from pointer 0 with all four requesting
        i_rst = 1'b1; tick(1); i_rst = 1'b0;
        base = done_seen + err_seen;
        g0   = grant_seen;
        add_txn(0, 1, 1, 32'h11, 32'hEE, 0);
        add_txn(1, 2, 1, 32'h22, 32'hDD, 0);
        add_txn(2, 3, 1, 32'h33, 32'hCC, 0);
        add_txn(3, 4, 1, 32'h44, 32'hBB, 0);
        add_txn(0, 1, 1, 32'h55, 32'hAA, 0);
        tick(1);
        i_req = 4'b1111;
        wait_grant("t2", g0 + 5, 200);
        i_req = 4'b0000;
        wait_fin("t2", base + 5, 50);
        chk("t2_events_left", 32'(exp_q.size()), 32'd0);
        tick(2);

        // Zero-length request on client 2
        base = done_seen + err_seen;
        g0   = grant_seen;
        add_txn(2, 2, 0, 32'h0, 32'h0, 0);
        tick(1);
        c0 = cyc;
        i_req = 4'b0100;
        wait_fin("t3", base + 1, 20);
        i_req = 4'b0000;
        chk_range("t3_done_latency", last_done_cyc - c0, 1, 2);
        chk("t3_no_grant", 32'(grant_seen - g0), 32'd0);
        tick(2);

        // Client 3 times out, client 0 served afterwards
        base = done_seen + err_seen;
        no_resp_mask = 4'b1000;
        add_txn(3, 7, 1, 32'h6B, 32'h0, 1);
        add_txn(0, 1, 1, 32'h7C, 32'h83, 0);
        tick(1);
        i_req = 4'b1001;
        wait_fin("t4a", base + 1, 100);
        i_req = 4'b0001;
        chk_range("t4_err_delay", last_err_cyc - take_cyc[3], 16, 17);
        wait_fin("t4b", base + 2, 100);
        i_req = 4'b0000;
        no_resp_mask = '0;
        chk("t4_events_left", 32'(exp_q.size()), 32'd0);
        tick(2);

        // Master not ready for 10 cycles, spurious rx while in SEND
        base = done_seen + err_seen;
        g0   = grant_seen;
        i_m_tx_ready = 1'b0;
        add_txn(1, 3, 1, 32'h5A, 32'hA5, 0);
        tick(1);
        i_req = 4'b0010;
        wait_grant("t5", g0 + 1, 20);
        for (int i = 0; i < 10; i++) begin
            spurious = (i == 4);
            tick(1);
        end
        spurious = 1'b0;
        i_m_tx_ready = 1'b1;
        rise_cyc = cyc;
        wait_fin("t5", base + 1, 50);
        i_req = 4'b0000;
        chk("t5_take_on_ready", 32'(take_cyc[1]), 32'(rise_cyc));
        chk("t5_events_left", 32'(exp_q.size()), 32'd0);
        tick(2);

        // Reset during WAIT_RX of a 4-byte transfer
        d0 = done_seen;
        e0 = err_seen;
        add_txn(0, 4, 4, 32'h44332211, 32'h0, 2);
        tick(1);
        i_req = 4'b0001;
        wait_q_empty("t6a", 30);
        tick(2);
        i_rst = 1'b1;
        i_req = 4'b0000;
        tick(1);
        i_rst = 1'b0;
        check_all_zero("t6_after_reset");
        tx_q[0].delete();
        tick(20);
        chk("t6_no_done", 32'(done_seen - d0), 32'd0);
        chk("t6_no_err", 32'(err_seen - e0), 32'd0);
        base = done_seen + err_seen;
        add_txn(0, 2, 1, 32'h96, 32'h69, 0);
        add_txn(3, 6, 1, 32'hF0, 32'h0F, 0);
        tick(1);
        i_req = 4'b1001;
        wait_fin("t6b", base + 1, 50);
        i_req = 4'b1000;
        wait_fin("t6c", base + 2, 50);
        i_req = 4'b0000;

        tick(5);
        chk("final_events_left", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
